// File: rtl/mz_clkdiv_prog.sv
// mz_clkdiv_prog
// Programmable square-wave divider and clock-enable generator on the system
// clock. The half-period is loaded at run time through a shadow register.
// Each new value is applied only when the counter restarts, at a terminal
// count or a sync restart, so the output never produces a runt pulse.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   en       run enable; the counter and outputs advance only while high
//   sync     phase restart: cnt and out return to 0 on this edge
//   div_wr   single-cycle divisor write strobe
//   div_val  new half-period, in cycles (0 behaves as 1)
//   out      registered divided square wave
//   tick     high for the first cycle in which a new out value is visible
//   rise     high for the first cycle in which out has just become 1
//   pend     a written divisor is waiting in the shadow register
//   cnt      current half-period counter value
module mz_clkdiv_prog #(
   parameter int WIDTH        = 8,
   parameter int DEFAULT_HALF = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             div_wr,
   input  logic [WIDTH-1:0] div_val,
   output logic             out,
   output logic             tick,
   output logic             rise,
   output logic             pend,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] half;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] tc_val;
   logic             tc;

   // A half-period of 0 is treated as 1, so the terminal count is 0 in both cases.
   assign tc_val = (half == '0) ? '0 : half - 1'b1;
   assign tc     = en && (c == tc_val);
   assign cnt    = c;

   always_ff @(posedge clk) begin
      if (rst) begin
         c      <= '0;
         out    <= 1'b0;
         tick   <= 1'b0;
         rise   <= 1'b0;
         pend   <= 1'b0;
         half   <= WIDTH'(DEFAULT_HALF);
         shadow <= WIDTH'(DEFAULT_HALF);
      end else if (sync || tc) begin
         // Counter restarts here, so this is the only safe point to change half.
         c <= '0;
         if (sync) begin
            out  <= 1'b0;
            tick <= 1'b0;
            rise <= 1'b0;
         end else begin
            out  <= ~out;
            tick <= 1'b1;
            rise <= ~out;
         end
         if (div_wr) begin
            half   <= div_val;
            shadow <= div_val;
            pend   <= 1'b0;
         end else if (pend) begin
            half <= shadow;
            pend <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         rise <= 1'b0;
         if (en) begin
            c <= c + 1'b1;
         end
         if (div_wr) begin
            shadow <= div_val;
            pend   <= 1'b1;
         end
      end
   end

endmodule

// File: doc/mz_clkdiv_prog.md
# mz_clkdiv_prog

Programmable clock-enable and square-wave divider for the MZ-80B graphics logic, a generalisation of the fixed divide-by-12 divider. It runs entirely on the system clock and produces:

- a registered square wave `out`;
- single-cycle `tick` and `rise` strobes for downstream logic.

The half-period is a parameterised-width value loaded at run time. A shadow register defers each load to a safe boundary, so no runt pulse is ever generated. Run/pause and phase-restart controls let software align the output to video timing.

## Interface
Parameters:
- `WIDTH`, default 8: width of the half-period counter and divisor registers.
- `DEFAULT_HALF`, default 6: half-period loaded at reset. Must be in 1..2^WIDTH-1.

Ports:
- `clk` in 1: single system clock, rising-edge active.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: run enable. Counter and outputs advance only while high.
- `sync` in 1: phase restart strobe.
- `div_wr` in 1: divisor write strobe.
- `div_val` in WIDTH: new half-period in cycles.
- `out` out 1: divided square wave, registered.
- `tick` out 1: one-cycle pulse in the cycle `out` shows a new value.
- `rise` out 1: one-cycle pulse when `out` has just become 1.
- `pend` out 1: a written divisor is waiting in the shadow register.
- `cnt` out WIDTH: current counter value, for debug and test.

## Operation
- State:
  - counter `c` (WIDTH bits);
  - active half-period `half`;
  - `shadow`;
  - `pend`;
  - `out`.
- Effective half-period `h` = max(`half`, 1). `half`=0 behaves exactly as 1.
- Terminal count (TC): `en`=1 and `c` == `h`-1.
- Per clock edge, first matching rule wins:
  1. `rst`: `c`=0, `out`=0, `tick`=0, `rise`=0, `pend`=0, `half`=`shadow`=`DEFAULT_HALF`.
  2. `sync`: `c`=0, `out`=0, `tick`=0, `rise`=0.
     - If `div_wr`: `half`=`shadow`=`div_val`, `pend`=0.
     - Else if `pend`: `half`=`shadow`, `pend`=0.
     - `en` is ignored this cycle.
  3. TC: `c`=0, `out`=~`out`, `tick`=1 next cycle, `rise`=1 next cycle if the new `out` is 1.
     - If `div_wr`: `half`=`shadow`=`div_val`, `pend`=0.
     - Else if `pend`: `half`=`shadow`, `pend`=0.
  4. `en`=1, not TC: `c`=`c`+1.
     - If `div_wr`: `shadow`=`div_val`, `pend`=1.
  5. `en`=0: `c` and `out` hold, `tick`=`rise`=0.
     - If `div_wr`: `shadow`=`div_val`, `pend`=1. The value is applied at the next TC or `sync`.
- Consecutive `div_wr` before application: the last value wins and `pend` stays 1.
- A new half-period governs the half-cycle that starts after the TC or `sync` at which it is applied.
- Lowering `half` below the current `c` cannot happen, because `half` changes only when `c` is reset to 0.

## Timing
- Reset values:
  - `out`=0, `tick`=0, `rise`=0, `pend`=0, `cnt`=0;
  - internal `half`=`shadow`=`DEFAULT_HALF`.
- With `en` held high, `out` toggles after every `h` enabled edges. Period = 2·`h` cycles, duty exactly 50%.
- After `rst` falls, `out` first changes on the h-th rising edge. With `DEFAULT_HALF`=6 that is edge 6, giving a 12-cycle period.
- `tick` and `rise` are registered. Each is high for exactly the one cycle in which the new `out` value is first visible.
- `h`=1: `out` toggles every enabled cycle and `tick` is continuously high.
- Maximum `half` = 2^WIDTH-1. `c` never wraps past `h`-1.
- `sync` takes effect on the same edge: `out`=0 and `cnt`=0 in the following cycle. The next toggle comes `h` enabled edges later.
- Pausing: while `en`=0 the phase is frozen. Re-asserting `en` continues the count from the held `c`.
- `div_wr` has no handshake: it is a single-cycle strobe that is always accepted. `pend` reflects the shadow state one cycle after the write.

## Test plan
- **Reset default:** assert `rst` 3 cycles, then release with `en`=1.
  - `out` rises after edge 6, falls after edge 12, rises after edge 18.
  - `tick` pulses 3 times.
  - `rise` pulses only on the 0→1 transitions.
- **Deferred load:** at `cnt`=2, pulse `div_wr`, `div_val`=3.
  - `pend`=1 until the TC at `cnt`=5.
  - `out` toggles, then `pend`=0, then the following half-periods are 3 cycles.
- **Write at TC:** pulse `div_wr` with `div_val`=2 in the TC cycle.
  - The new value is applied immediately and `pend` stays 0.
  - The next toggle is 2 cycles later.
- **Pause:** drop `en` for 5 cycles at `cnt`=3.
  - `cnt` holds 3, `out` holds, `tick`=0.
  - After re-enable, the toggle comes 3 edges later (h=6).
- **Sync:** pulse `sync` at `cnt`=4 with `out`=1 and a pending `div_val`=4.
  - The next cycle shows `out`=0, `cnt`=0, `pend`=0.
  - `out` rises 4 edges later.
  - Repeat with `sync` and `en`=0 together: the restart still occurs.
- **Extremes:** set `div_val`=0 then 1.
  - `out` toggles every cycle and `tick` stays high.
  - With `div_val`=255 (WIDTH=8): period 510 cycles, `cnt` peaks at 254 and never wraps.
